// File: rtl/ring_phase_decoder_if.sv
// Sample and status bundle between a ring-phase source and ring_phase_decoder.
// master drives the ring samples; slave (the decoder) returns phase and lock status.
interface ring_phase_decoder_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned REV_W = 8
);
    localparam int unsigned IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             in_valid;
    logic [WIDTH-1:0] ring_in;
    logic             dir;
    logic [IDXW-1:0]  index;
    logic             index_valid;
    logic             locked;
    logic             step_err;
    logic             onehot_err;
    logic [REV_W-1:0] rev_count;
    logic             rev_pulse;

    modport master (
        output in_valid, ring_in, dir,
        input  index, index_valid, locked, step_err, onehot_err, rev_count, rev_pulse
    );

    modport slave (
        input  in_valid, ring_in, dir,
        output index, index_valid, locked, step_err, onehot_err, rev_count, rev_pulse
    );
endinterface

// File: rtl/ring_phase_decoder.sv
// Checks a one-hot ring each qualified sample, decodes its phase, tracks lock on the
// expected rotation direction and counts completed revolutions while locked.
module ring_phase_decoder #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned REV_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ring_phase_decoder_if.slave  bus
);
    localparam int unsigned IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {StHunt, StTrack, StLocked} state_e;

    state_e             r_state, w_state_nxt;
    logic [IDXW-1:0]    r_ref, w_ref_nxt;
    logic [GW-1:0]      r_good, w_good_nxt;
    logic               r_dir, w_dir_nxt;
    logic [IDXW-1:0]    r_index, w_index_nxt;
    logic               r_index_valid, w_index_valid_nxt;
    logic               r_locked, w_locked_nxt;
    logic               r_step_err, w_step_err_nxt;
    logic               r_onehot_err, w_onehot_err_nxt;
    logic [REV_W-1:0]   r_rev_count, w_rev_count_nxt;
    logic               r_rev_pulse, w_rev_pulse_nxt;

    logic               w_onehot;
    logic [IDXW-1:0]    w_pos;
    logic [IDXW-1:0]    w_exp;
    logic               w_match;
    logic               w_wrap;
    logic [GW-1:0]      w_good_inc;

    // x & (x-1) clears the lowest set bit, so zero there means at most one bit was set.
    assign w_onehot = (bus.ring_in != '0) &&
                      ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);

    always_comb begin
        w_pos = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) w_pos = IDXW'(i);
        end
    end

    assign w_exp = bus.dir ? ((r_ref == '0) ? IDX_LAST : r_ref - IDX_ONE)
                           : ((r_ref == IDX_LAST) ? '0 : r_ref + IDX_ONE);
    assign w_match    = (w_pos == w_exp);
    assign w_wrap     = bus.dir ? (r_ref == '0) : (r_ref == IDX_LAST);
    assign w_good_inc = r_good + GW'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_ref_nxt         = r_ref;
        w_good_nxt        = r_good;
        w_dir_nxt         = r_dir;
        w_index_nxt       = r_index;
        w_index_valid_nxt = r_index_valid;
        w_locked_nxt      = r_locked;
        w_step_err_nxt    = 1'b0;
        w_onehot_err_nxt  = 1'b0;
        w_rev_count_nxt   = r_rev_count;
        w_rev_pulse_nxt   = 1'b0;

        if (bus.in_valid) begin
            w_dir_nxt = bus.dir;
            if (!w_onehot) begin
                w_onehot_err_nxt  = 1'b1;
                w_index_valid_nxt = 1'b0;
                w_locked_nxt      = 1'b0;
                w_good_nxt        = '0;
                w_state_nxt       = StHunt;
            end else begin
                w_index_nxt       = w_pos;
                w_index_valid_nxt = 1'b1;
                w_ref_nxt         = w_pos;
                case (r_state)
                    StTrack, StLocked: begin
                        if (bus.dir != r_dir) begin
                            // Direction change restarts acquisition silently.
                            w_state_nxt  = StTrack;
                            w_good_nxt   = '0;
                            w_locked_nxt = 1'b0;
                        end else if (!w_match) begin
                            w_step_err_nxt = 1'b1;
                            w_state_nxt    = StTrack;
                            w_good_nxt     = '0;
                            w_locked_nxt   = 1'b0;
                        end else if (r_state == StTrack) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == GW'(LOCK_CNT)) begin
                                w_state_nxt  = StLocked;
                                w_locked_nxt = 1'b1;
                            end
                        end else if (w_wrap) begin
                            w_rev_count_nxt = r_rev_count + REV_W'(1);
                            w_rev_pulse_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = StTrack;
                        w_good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StHunt;
            r_ref         <= '0;
            r_good        <= '0;
            r_dir         <= 1'b0;
            r_index       <= '0;
            r_index_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_step_err    <= 1'b0;
            r_onehot_err  <= 1'b0;
            r_rev_count   <= '0;
            r_rev_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ref         <= w_ref_nxt;
            r_good        <= w_good_nxt;
            r_dir         <= w_dir_nxt;
            r_index       <= w_index_nxt;
            r_index_valid <= w_index_valid_nxt;
            r_locked      <= w_locked_nxt;
            r_step_err    <= w_step_err_nxt;
            r_onehot_err  <= w_onehot_err_nxt;
            r_rev_count   <= w_rev_count_nxt;
            r_rev_pulse   <= w_rev_pulse_nxt;
        end
    end

    assign bus.index       = r_index;
    assign bus.index_valid = r_index_valid;
    assign bus.locked      = r_locked;
    assign bus.step_err    = r_step_err;
    assign bus.onehot_err  = r_onehot_err;
    assign bus.rev_count   = r_rev_count;
    assign bus.rev_pulse   = r_rev_pulse;
endmodule

// File: tb/tb_ring_phase_decoder.sv
// Bench for ring_phase_decoder: directed scenarios with literal expectations, then
// random samples checked every cycle against a behavioural model.
module tb_ring_phase_decoder;
    localparam int W    = 5;
    localparam int LOCK = 2;
    localparam int RW   = 8;

    logic clk = 1'b0;
    logic reset;

    ring_phase_decoder_if #(.WIDTH(W), .REV_W(RW)) bus ();

    ring_phase_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .REV_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = hunting, 1 = tracking, 2 = locked.
    typedef struct packed {
        int   mode;
        int   refi;
        int   good;
        logic sdir;
        int   index;
        logic iv;
        logic lk;
        logic se;
        logic oe;
        logic rp;
        int   rc;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(mstate_t s, logic v, logic [W-1:0] r, logic d);
        mstate_t n = s;
        int pos = 0;
        int exp_pos;
        n.se = 1'b0;
        n.oe = 1'b0;
        n.rp = 1'b0;
        if (!v) return n;
        n.sdir = d;
        if ($countones(r) != 1) begin
            n.oe   = 1'b1;
            n.iv   = 1'b0;
            n.lk   = 1'b0;
            n.mode = 0;
            n.good = 0;
            return n;
        end
        for (int i = 0; i < W; i++) if (r[i]) pos = i;
        exp_pos = d ? (s.refi + W - 1) % W : (s.refi + 1) % W;
        n.index = pos;
        n.iv    = 1'b1;
        n.refi  = pos;
        if (s.mode == 0) begin
            n.mode = 1;
            n.good = 0;
        end else if (d != s.sdir) begin
            n.mode = 1;
            n.good = 0;
            n.lk   = 1'b0;
        end else if (pos != exp_pos) begin
            n.se   = 1'b1;
            n.mode = 1;
            n.good = 0;
            n.lk   = 1'b0;
        end else if (s.mode == 1) begin
            n.good = s.good + 1;
            if (n.good >= LOCK) begin
                n.mode = 2;
                n.lk   = 1'b1;
            end
        end else if (pos == (d ? W - 1 : 0)) begin
            n.rc = (s.rc + 1) % (1 << RW);
            n.rp = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_next(m, bus.in_valid, bus.ring_in, bus.dir);
    end

    always @(negedge clk) begin
        chk("cyc_index",       int'(bus.index),       m.index);
        chk("cyc_index_valid", int'(bus.index_valid), int'(m.iv));
        chk("cyc_locked",      int'(bus.locked),      int'(m.lk));
        chk("cyc_step_err",    int'(bus.step_err),    int'(m.se));
        chk("cyc_onehot_err",  int'(bus.onehot_err),  int'(m.oe));
        chk("cyc_rev_count",   int'(bus.rev_count),   m.rc);
        chk("cyc_rev_pulse",   int'(bus.rev_pulse),   int'(m.rp));
    end

    // Called at posedge+1: drives one cycle and returns just after the edge that sampled it.
    task automatic apply(input logic v, input logic [W-1:0] r, input logic d);
        bus.in_valid = v;
        bus.ring_in  = r;
        bus.dir      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int idx, input int iv, input int lk,
                              input int se, input int oe, input int rc, input int rp);
        chk({tag, ".index"},       int'(bus.index),       idx);
        chk({tag, ".index_valid"}, int'(bus.index_valid), iv);
        chk({tag, ".locked"},      int'(bus.locked),      lk);
        chk({tag, ".step_err"},    int'(bus.step_err),    se);
        chk({tag, ".onehot_err"},  int'(bus.onehot_err),  oe);
        chk({tag, ".rev_count"},   int'(bus.rev_count),   rc);
        chk({tag, ".rev_pulse"},   int'(bus.rev_pulse),   rp);
    endtask

    initial begin
        int p;
        logic d;
        logic v;
        logic [W-1:0] r;
        int sel;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.ring_in  = '0;
        bus.dir      = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // Acquire and lock, dir=0
        apply(1'b1, 5'b00001, 1'b0); expect_out("s1a", 0, 1, 0, 0, 0, 0, 0);
        apply(1'b1, 5'b00010, 1'b0); expect_out("s1b", 1, 1, 0, 0, 0, 0, 0);
        apply(1'b1, 5'b00100, 1'b0); expect_out("s1c", 2, 1, 1, 0, 0, 0, 0);
        apply(1'b1, 5'b01000, 1'b0); expect_out("s1d", 3, 1, 1, 0, 0, 0, 0);
        // Revolutions
        apply(1'b1, 5'b10000, 1'b0); expect_out("s2a", 4, 1, 1, 0, 0, 0, 0);
        apply(1'b1, 5'b00001, 1'b0); expect_out("s2b", 0, 1, 1, 0, 0, 1, 1);
        apply(1'b1, 5'b00010, 1'b0); expect_out("s2c", 1, 1, 1, 0, 0, 1, 0);
        apply(1'b1, 5'b00100, 1'b0);
        apply(1'b1, 5'b01000, 1'b0);
        apply(1'b1, 5'b10000, 1'b0); expect_out("s2d", 4, 1, 1, 0, 0, 1, 0);
        apply(1'b1, 5'b00001, 1'b0); expect_out("s2e", 0, 1, 1, 0, 0, 2, 1);
        // Step error and relock; relock step does not count a revolution
        apply(1'b1, 5'b00010, 1'b0); expect_out("s3a", 1, 1, 1, 0, 0, 2, 0);
        apply(1'b1, 5'b01000, 1'b0); expect_out("s3b", 3, 1, 0, 1, 0, 2, 0);
        apply(1'b1, 5'b10000, 1'b0); expect_out("s3c", 4, 1, 0, 0, 0, 2, 0);
        apply(1'b1, 5'b00001, 1'b0); expect_out("s3d", 0, 1, 1, 0, 0, 2, 0);
        // One-hot violations
        apply(1'b1, 5'b00110, 1'b0); expect_out("s4a", 0, 0, 0, 0, 1, 2, 0);
        apply(1'b1, 5'b00000, 1'b0); expect_out("s4b", 0, 0, 0, 0, 1, 2, 0);
        apply(1'b1, 5'b00100, 1'b0); expect_out("s4c", 2, 1, 0, 0, 0, 2, 0);
        // dir=1
        apply(1'b1, 5'b00001, 1'b1); expect_out("s5a", 0, 1, 0, 0, 0, 2, 0);
        apply(1'b1, 5'b10000, 1'b1); expect_out("s5b", 4, 1, 0, 0, 0, 2, 0);
        apply(1'b1, 5'b01000, 1'b1); expect_out("s5c", 3, 1, 1, 0, 0, 2, 0);
        apply(1'b1, 5'b00100, 1'b1);
        apply(1'b1, 5'b00010, 1'b1);
        apply(1'b1, 5'b00001, 1'b1); expect_out("s5d", 0, 1, 1, 0, 0, 2, 0);
        apply(1'b1, 5'b10000, 1'b1); expect_out("s5e", 4, 1, 1, 0, 0, 3, 1);
        apply(1'b1, 5'b00001, 1'b0); expect_out("s5f", 0, 1, 0, 0, 0, 3, 0);
        // Gaps hold state
        apply(1'b1, 5'b00010, 1'b0); expect_out("s6a", 1, 1, 0, 0, 0, 3, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 5'b11111, 1'b1); expect_out("s6gap", 1, 1, 0, 0, 0, 3, 0);
        end
        apply(1'b1, 5'b00100, 1'b0); expect_out("s6b", 2, 1, 1, 0, 0, 3, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 5'b00000, 1'b0); expect_out("s6gap2", 2, 1, 1, 0, 0, 3, 0);
        end
        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1 expect_out("s6rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        p = 0;
        d = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            v = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 4) d = ~d;
            sel = $urandom_range(0, 99);
            if (sel < 75)      r = W'(1) << (d ? (p + W - 1) % W : (p + 1) % W);
            else if (sel < 85) r = W'(1) << $urandom_range(0, W - 1);
            else               r = W'($urandom_range(0, (1 << W) - 1));
            apply(v, r, d);
            if (v && $countones(r) == 1) begin
                for (int i = 0; i < W; i++) if (r[i]) p = i;
            end
            if (k % 500 == 250) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end

        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
